// File: rtl/spinner_pkg.sv
// spinner_pkg: shared types and helpers for the spinner_array position generator.
//   ext_delta_t  - per-channel external source word {toggle, signed delta}
//   spin_mode_e  - accumulator overflow behaviour (wrap vs. saturate)
//   sat_add      - saturating add used by clamp (paddle) mode
package spinner_pkg;

  localparam int EXT_W = 9;

  typedef struct packed {
    logic              toggle;
    logic signed [7:0] delta;   // whole counts, two's complement
  } ext_delta_t;

  typedef enum logic {
    SPIN_WRAP  = 1'b0,
    SPIN_CLAMP = 1'b1
  } spin_mode_e;

  // Adds a signed delta to an unsigned value and clips the result to [0, hi].
  function automatic int sat_add(input int value, input int delta, input int hi);
    int sum;
    sum = value + delta;
    if (sum < 0)
      return 0;
    else if (sum > hi)
      return hi;
    return sum;
  endfunction

endpackage

// File: rtl/spinner_array_if.sv
// spinner_array_if: input/output bundle between hps_io-side logic and spinner_array.
//   strobe   frame strobe (vsync), rising edge used
//   minus/plus/fast/clamp/ext_en  per-channel controls
//   ext_in   per channel 9 bits: [8] toggle, [7:0] signed delta
//   spin_out per channel OUT_W-bit position
//   moved    per channel one-cycle change pulse
// master drives the controls, slave (spinner_array) drives positions.
interface spinner_array_if #(
  parameter int CHANNELS = 2,
  parameter int OUT_W    = 8
);
  import spinner_pkg::*;

  logic                        strobe;
  logic [CHANNELS-1:0]         minus;
  logic [CHANNELS-1:0]         plus;
  logic [CHANNELS-1:0]         fast;
  logic [CHANNELS-1:0]         clamp;
  logic [CHANNELS-1:0]         ext_en;
  logic [EXT_W*CHANNELS-1:0]   ext_in;
  logic [OUT_W*CHANNELS-1:0]   spin_out;
  logic [CHANNELS-1:0]         moved;

  modport master (
    output strobe, minus, plus, fast, clamp, ext_en, ext_in,
    input  spin_out, moved
  );

  modport slave (
    input  strobe, minus, plus, fast, clamp, ext_en, ext_in,
    output spin_out, moved
  );

endinterface

// File: rtl/spinner_chan.sv
// spinner_chan: one position channel of spinner_array.
//   Accumulates digital button steps (on tick) and external deltas (on toggle
//   change) into an OUT_W.FRAC_W fixed-point accumulator that wraps or saturates.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   tick                      one-cycle frame event shared by all channels
//   minus, plus, fast, clamp  digital controls and overflow mode
//   ext_en, ext_in            external delta source
//   spin_out                  integer part of the accumulator
//   moved                     one-cycle pulse when spin_out changes
// Optional feature: SPINNER_ACCEL_EN adds a hold counter that forces STEP_FAST
// after ACCEL_FRAMES consecutive single-direction ticks.
module spinner_chan
  import spinner_pkg::*;
#(
  parameter int OUT_W        = 8,
  parameter int FRAC_W       = 4,
  parameter int STEP_SLOW    = 15,
  parameter int STEP_FAST    = 25,
  parameter int ACCEL_FRAMES = 5,
  parameter int RESET_POS    = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             tick,
  input  logic             minus,
  input  logic             plus,
  input  logic             fast,
  input  logic             clamp,
  input  logic             ext_en,
  input  ext_delta_t       ext_in,
  output logic [OUT_W-1:0] spin_out,
  output logic             moved
);

  localparam int ACC_W = OUT_W + FRAC_W;
  localparam int SUM_W = ACC_W + 2;
  localparam int ACC_MAX = (1 << ACC_W) - 1;
  localparam logic [ACC_W-1:0] ACC_RESET = ACC_W'(RESET_POS) << FRAC_W;

  // The clamp path evaluates in 32-bit int arithmetic.
  if (ACCEL_FRAMES < 1 || ACC_W > 30) begin : g_bad_cfg
    $error("spinner_chan: ACCEL_FRAMES must be >= 1 and OUT_W+FRAC_W <= 30");
  end

  logic [ACC_W-1:0]        acc;
  logic [ACC_W-1:0]        acc_next;
  logic                    tog_q;
  logic                    ext_evt;
  logic                    update;
  logic                    use_fast;
  logic signed [SUM_W-1:0] dig_delta;
  logic signed [SUM_W-1:0] ext_delta;
  logic signed [SUM_W-1:0] delta_sum;
  spin_mode_e              mode;

  // tog_q follows the toggle unconditionally, so toggles seen while disabled are dropped.
  assign ext_evt = ext_en && (ext_in.toggle != tog_q);
  assign update  = tick || ext_evt;
  assign mode    = spin_mode_e'(clamp);

`ifdef SPINNER_ACCEL_EN
  localparam int CNT_W = $clog2(ACCEL_FRAMES + 1);

  logic [CNT_W-1:0] hold_cnt;
  logic             last_plus;

  assign use_fast = fast || (hold_cnt == CNT_W'(ACCEL_FRAMES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt  <= '0;
      last_plus <= 1'b0;
    end else if (tick) begin
      if (plus ^ minus) begin
        last_plus <= plus;
        if (hold_cnt != '0 && plus != last_plus)
          hold_cnt <= '0;
        else if (hold_cnt != CNT_W'(ACCEL_FRAMES))
          hold_cnt <= hold_cnt + 1'b1;
      end else begin
        hold_cnt <= '0;
      end
    end
  end
`else
  assign use_fast = fast;
`endif

  // NOTE: every always_comb output gets a default first, otherwise an untaken branch infers a latch.
  always_comb begin
    dig_delta = '0;
    if (tick && (plus ^ minus)) begin
      dig_delta = use_fast ? SUM_W'(STEP_FAST) : SUM_W'(STEP_SLOW);
      if (minus)
        dig_delta = -dig_delta;
    end
  end

  assign ext_delta = ext_evt ? (SUM_W'(ext_in.delta) <<< FRAC_W) : '0;
  assign delta_sum = dig_delta + ext_delta;

  // Wrap keeps the low ACC_W bits of the sum; clamp saturates the full signed sum.
  always_comb begin
    acc_next = acc + delta_sum[ACC_W-1:0];
    if (mode == SPIN_CLAMP)
      acc_next = ACC_W'(sat_add(int'(acc), int'(delta_sum), ACC_MAX));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc   <= ACC_RESET;
      tog_q <= 1'b0;
      moved <= 1'b0;
    end else begin
      tog_q <= ext_in.toggle;
      moved <= update && (acc_next[ACC_W-1:FRAC_W] != acc[ACC_W-1:FRAC_W]);
      if (update)
        acc <= acc_next;
    end
  end

  assign spin_out = acc[ACC_W-1:FRAC_W];

endmodule

// File: rtl/spinner_array.sv
// spinner_array: multi-channel rotary/paddle position generator.
//   Detects the rising edge of the frame strobe once and fans the resulting
//   tick out to CHANNELS independent spinner_chan instances.
// Ports:
//   clk      system clock (clk_sys)
//   reset_n  asynchronous active-low reset
//   bus      spinner_array_if.slave: strobe, per-channel controls, ext_in,
//            spin_out, moved
// Optional feature: define SPINNER_ACCEL_EN to enable hold-to-accelerate.
module spinner_array
  import spinner_pkg::*;
#(
  parameter int CHANNELS     = 2,
  parameter int OUT_W        = 8,
  parameter int FRAC_W       = 4,
  parameter int STEP_SLOW    = 15,
  parameter int STEP_FAST    = 25,
  parameter int ACCEL_FRAMES = 5,
  parameter int RESET_POS    = 0
) (
  input  logic           clk,
  input  logic           reset_n,
  spinner_array_if.slave bus
);

  logic strobe_q;
  logic tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      strobe_q <= 1'b0;
    else
      strobe_q <= bus.strobe;
  end

  assign tick = bus.strobe & ~strobe_q;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    spinner_chan #(
      .OUT_W        (OUT_W),
      .FRAC_W       (FRAC_W),
      .STEP_SLOW    (STEP_SLOW),
      .STEP_FAST    (STEP_FAST),
      .ACCEL_FRAMES (ACCEL_FRAMES),
      .RESET_POS    (RESET_POS)
    ) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .tick     (tick),
      .minus    (bus.minus[c]),
      .plus     (bus.plus[c]),
      .fast     (bus.fast[c]),
      .clamp    (bus.clamp[c]),
      .ext_en   (bus.ext_en[c]),
      .ext_in   (ext_delta_t'(bus.ext_in[EXT_W*c +: EXT_W])),
      .spin_out (bus.spin_out[OUT_W*c +: OUT_W]),
      .moved    (bus.moved[c])
    );
  end

endmodule
